i2c_target_regbank: RTL

- Synthesizable I2C target (slave) controller with an internal parametrised register bank.
- Successor to the fixed-width I2C globals: supports 7- or 10-bit slave addressing selectable at runtime, parametrised register depth and register-address width, and pointer auto-increment.
- Sits behind open-drain pad logic on the DUT side of the i2c_avip bench. Sampled with a fast system clock; SCL/SDA are oversampled.

---
 rtl/i2c_globals_pkg.sv | 5 +
 rtl/i2c_target_pkg.sv | 11 +
 rtl/i2c_target_regbank_bus_sync.sv | 31 +++
 rtl/i2c_target_regbank.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/i2c_globals_pkg.sv
// Shared I2C bus enums used by the bench agents and the target controllers.
package i2c_globals_pkg;
  typedef enum logic { SEVEN_BIT = 1'b0, TEN_BIT = 1'b1 } slave_address_width_e;
  typedef enum logic { WRITE = 1'b0, READ = 1'b1 } read_write_e;
endpackage

// File: rtl/i2c_target_pkg.sv
// Types and constants for the I2C target register bank.
package i2c_target_pkg;
  import i2c_globals_pkg::*;

  typedef enum logic [3:0] {
    IDLE, ADDR1, ACK1, ADDR2, ACK2, REG, ACK_REG, WDATA, ACK_W, RDATA, RACK
  } state_e;

  localparam logic [4:0] TEN_BIT_PREFIX    = 5'b11110;
  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;
endpackage

// File: rtl/i2c_target_regbank_bus_sync.sv
// SCL/SDA synchronizers with SCL edge strobes and START/STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_raw,
  input  logic sda_raw,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  // [1:0] is the synchronizer, [2] holds the previous synced value for edges
  logic [2:0] scl_pipe, sda_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
    end else begin
      scl_pipe <= {scl_pipe[1:0], scl_raw};
      sda_pipe <= {sda_pipe[1:0], sda_raw};
    end
  end

  assign sda      = sda_pipe[1];
  assign scl_rise =  scl_pipe[1] & ~scl_pipe[2];
  assign scl_fall = ~scl_pipe[1] &  scl_pipe[2];
  assign start    = scl_pipe[1] & scl_pipe[2] &  sda_pipe[2] & ~sda_pipe[1];
  assign stop     = scl_pipe[1] & scl_pipe[2] & ~sda_pipe[2] &  sda_pipe[1];
endmodule

// File: rtl/i2c_target_regbank.sv
// I2C target with 7/10-bit addressing, auto-incrementing register bank.
// Define I2C_TARGET_GENERAL_CALL_EN to accept 7-bit general-call writes.
module i2c_target_regbank
  import i2c_globals_pkg::*, i2c_target_pkg::*;
#(
  parameter int                             SLAVE_ADDRESS_WIDTH    = 10,
  parameter logic [SLAVE_ADDRESS_WIDTH-1:0] SLAVE_ADDRESS          = 10'h050,
  parameter int                             REGISTER_ADDRESS_WIDTH = 8,
  parameter int                             NO_OF_REGISTERS        = 16,
  parameter int                             DATA_LENGTH            = 8
) (
  input  logic                              pclk,
  input  logic                              areset,
  input  logic                              scl_i,
  input  logic                              sda_i,
  output logic                              sda_oe,
  input  logic                              addr_mode_i,
  output logic                              wr_valid,
  output logic [REGISTER_ADDRESS_WIDTH-1:0] wr_addr,
  output logic [7:0]                        wr_data,
  output logic                              busy
);
  localparam int RAW = REGISTER_ADDRESS_WIDTH;
  localparam int IW  = (NO_OF_REGISTERS > 1) ? $clog2(NO_OF_REGISTERS) : 1;
  localparam logic [9:0]     OWN  = 10'(SLAVE_ADDRESS);
  localparam logic [RAW-1:0] LAST = RAW'(NO_OF_REGISTERS - 1);
`ifdef I2C_TARGET_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  if (DATA_LENGTH != 8) begin : g_bad_data_length
    $error("i2c_target_regbank: DATA_LENGTH must be 8");
  end

  logic sda, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk(pclk), .rst_n(areset), .scl_raw(scl_i), .sda_raw(sda_i),
    .sda(sda), .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
  );

  state_e               state;
  slave_address_width_e mode;
  read_write_e          rw;
  logic [2:0]           bit_cnt;
  logic [6:0]           shreg;
  logic [7:0]           tx;
  logic [RAW-1:0]       ptr;
  logic                 ack_ph, tenbit_ok, gc;
  logic [7:0]           regs [NO_OF_REGISTERS];

  logic [7:0]     rx_byte, rd_byte;
  logic [RAW-1:0] ptr_nxt;
  logic           gc_hit;

  assign rx_byte = {shreg, sda};
  assign rd_byte = regs[ptr[IW-1:0]];
  assign ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
  assign gc_hit  = GC_EN && rx_byte[7:1] == GENERAL_CALL_ADDR && rx_byte[0] == WRITE;

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state     <= IDLE;
      mode      <= SEVEN_BIT;
      rw        <= WRITE;
      bit_cnt   <= 3'd7;
      shreg     <= '0;
      tx        <= '0;
      ptr       <= '0;
      ack_ph    <= 1'b0;
      tenbit_ok <= 1'b0;
      gc        <= 1'b0;
      sda_oe    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < NO_OF_REGISTERS; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (state == IDLE) mode <= slave_address_width_e'(addr_mode_i);
      // bus conditions take priority over any SCL edge seen in the same cycle
      if (start) begin
        state <= ADDR1; bit_cnt <= 3'd7; sda_oe <= 1'b0; ack_ph <= 1'b0; gc <= 1'b0;
      end else if (stop) begin
        state <= IDLE; busy <= 1'b0; sda_oe <= 1'b0; ack_ph <= 1'b0; gc <= 1'b0;
        tenbit_ok <= 1'b0;
      end else begin
        case (state)
          ADDR1, ADDR2, REG, WDATA: if (scl_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              unique case (state)
                ADDR1: begin
                  rw    <= read_write_e'(rx_byte[0]);
                  state <= IDLE;
                  if (mode == SEVEN_BIT) begin
                    if (rx_byte[7:1] == OWN[6:0]) state <= ACK1;
                    else if (gc_hit) begin gc <= 1'b1; state <= ACK1; end
                  end else if (rx_byte[7:3] == TEN_BIT_PREFIX && rx_byte[2:1] == OWN[9:8] &&
                               (rx_byte[0] == WRITE || tenbit_ok))
                    state <= ACK1;
                end
                ADDR2: if (rx_byte == OWN[7:0]) begin
                  tenbit_ok <= 1'b1; state <= ACK2;
                end else state <= IDLE;
                REG: if (32'(rx_byte) < NO_OF_REGISTERS) begin
                  ptr <= rx_byte[RAW-1:0]; state <= ACK_REG;
                end else state <= IDLE;
                default: begin
                  wr_valid <= 1'b1;
                  wr_data  <= rx_byte;
                  state    <= ACK_W;
                  if (gc) wr_addr <= '1;
                  else begin
                    wr_addr <= ptr; regs[ptr[IW-1:0]] <= rx_byte; ptr <= ptr_nxt;
                  end
                end
              endcase
            end
          end
          ACK1, ACK2, ACK_REG, ACK_W: if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe <= 1'b1; ack_ph <= 1'b1;
              if (state == ACK1) busy <= 1'b1;
            end else begin
              ack_ph <= 1'b0; sda_oe <= 1'b0; bit_cnt <= 3'd7;
              unique case (state)
                ACK1:
                  if (rw == READ) begin
                    state <= RDATA; tx <= rd_byte; sda_oe <= ~rd_byte[7];
                  end else if (gc) state <= WDATA;
                  else if (mode == TEN_BIT) state <= ADDR2;
                  else state <= REG;
                ACK2:    state <= REG;
                default: state <= WDATA;
              endcase
            end
          end
          RDATA: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe <= 1'b0; state <= RACK;
            end else begin
              bit_cnt <= bit_cnt - 3'd1; sda_oe <= ~tx[bit_cnt - 3'd1];
            end
          end
          RACK: begin
            // master ACK is sampled on the rise; next byte goes out on the fall
            if (scl_rise && !ack_ph) begin
              if (!sda) begin ptr <= ptr_nxt; ack_ph <= 1'b1; end
              else state <= IDLE;
            end else if (scl_fall && ack_ph) begin
              ack_ph <= 1'b0; tx <= rd_byte; sda_oe <= ~rd_byte[7]; bit_cnt <= 3'd7;
              state  <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
